// File: rtl/nios2_hex_pkg.sv
// Shared definitions for the multi-digit seven-segment controller:
// register word addresses and the active-low hex segment table.
package nios2_hex_pkg;

  localparam logic [3:0] ADDR_DIGIT0 = 4'd0;
  localparam logic [3:0] ADDR_DECODE = 4'd8;
  localparam logic [3:0] ADDR_BLINK  = 4'd9;
  localparam logic [3:0] ADDR_DIV    = 4'd10;
  localparam logic [3:0] ADDR_STATUS = 4'd11;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/nios2_hex_blink_timer.sv
// Blink phase generator. The phase toggles once every `div` cycles; a
// divider of zero parks counter and phase at 0. While div_wr is high,
// `div` carries the value being written, so the restart reloads with it.
module nios2_hex_blink_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             div_wr,
  output logic             phase
);

  // Cycles remaining until the next toggle (down-counter, toggle at zero).
  logic [DIV_W-1:0] remain;

  // Down-count to terminal count, toggle phase, reload; a divider write restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      remain <= '0;
      phase  <= 1'b0;
    end else if (div_wr) begin
      phase  <= 1'b0;
      remain <= (div == '0) ? '0 : div - DIV_W'(1);
    end else if (div == '0) begin
      remain <= '0;
      phase  <= 1'b0;
    end else if (remain == '0) begin
      phase  <= ~phase;
      remain <= div - DIV_W'(1);
    end else begin
      remain <= remain - DIV_W'(1);
    end
  end

endmodule

// File: rtl/nios2_hex_multi.sv
// Avalon-MM multi-digit seven-segment controller: per-digit registers,
// optional hex decode, hardware blink and a registered out_port.
// Optional feature macro: NIOS2_HEX_DECODE_EN (DECODE register + decoder).
module nios2_hex_multi
  import nios2_hex_pkg::*;
#(
  parameter int         NUM_DIGITS = 6,
  parameter logic [7:0] RESET_VAL  = 8'h7F,
  parameter logic [7:0] BLANK_VAL  = 8'hFF,
  parameter int         DIV_W      = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*8-1:0] out_port
);

  logic [7:0]              digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [DIV_W-1:0]        div_reg;
  logic                    phase;
  logic                    wr_en;
  logic                    div_wr;
  logic [DIV_W-1:0]        div_eff;
  logic [NUM_DIGITS*8-1:0] out_next;
  logic [7:0]              digit_val;
`ifdef NIOS2_HEX_DECODE_EN
  logic [NUM_DIGITS-1:0]   decode_mask;
`endif

  assign wr_en   = chipselect && !write_n;
  assign div_wr  = wr_en && (address == ADDR_DIV);
  assign div_eff = div_wr ? writedata[DIV_W-1:0] : div_reg;

  // Register file; digit addresses beyond NUM_DIGITS simply match nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= RESET_VAL;
      blink_mask  <= '0;
      div_reg     <= '0;
`ifdef NIOS2_HEX_DECODE_EN
      decode_mask <= '0;
`endif
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == 4'(ADDR_DIGIT0 + 4'(i))) digit[i] <= writedata[7:0];
      end
      if (address == ADDR_BLINK) blink_mask <= writedata[NUM_DIGITS-1:0];
      if (address == ADDR_DIV)   div_reg    <= writedata[DIV_W-1:0];
`ifdef NIOS2_HEX_DECODE_EN
      if (address == ADDR_DECODE) decode_mask <= writedata[NUM_DIGITS-1:0];
`endif
    end
  end

  nios2_hex_blink_timer #(
    .DIV_W (DIV_W)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .div    (div_eff),
    .div_wr (div_wr),
    .phase  (phase)
  );

  // Zero-latency read mux, zero-extended; unmapped addresses read 0.
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == 4'(ADDR_DIGIT0 + 4'(i))) readdata[7:0] = digit[i];
    end
    case (address)
`ifdef NIOS2_HEX_DECODE_EN
      ADDR_DECODE: readdata[NUM_DIGITS-1:0] = decode_mask;
`endif
      ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink_mask;
      ADDR_DIV:    readdata[DIV_W-1:0]      = div_reg;
      ADDR_STATUS: readdata[0]              = phase;
      default: ;
    endcase
  end

  // Per-digit value: raw or decoded, then blanked during the blink off phase.
  always_comb begin
    out_next  = '0;
    digit_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_val = digit[i];
`ifdef NIOS2_HEX_DECODE_EN
      if (decode_mask[i]) digit_val = {~digit[i][7], seg7_decode(digit[i][3:0])};
`endif
      if (blink_mask[i] && phase) digit_val = BLANK_VAL;
      out_next[8*i +: 8] = digit_val;
    end
  end

  // Single output register stage driving the board pins.
  always_ff @(posedge clk) begin
    if (reset) out_port <= {NUM_DIGITS{RESET_VAL}};
    else       out_port <= out_next;
  end

endmodule
